// File: rtl/lvds_multi_align.sv
// lvds_multi_align: multi-lane LVDS word aligner (rx_clk domain).
// Each lane pulses its bitslip until PATTERN has been seen MATCH_CNT times in
// a row, then holds lock. While training, MISS_MAX consecutive misses drop the
// lock and alignment restarts.
// Optional build macro LVDS_ALIGN_SLIPCNT_EN adds a saturating per-lane
// slip_cnt output (8 bits per lane).

module lvds_align_lane #(
    parameter int               DESER     = 10,
    parameter logic [DESER-1:0] PATTERN   = 10'h3E0,
    parameter int               MATCH_CNT = 16,
    parameter int               SLIP_WAIT = 4,
    parameter int               MISS_MAX  = 4
) (
    input  logic             rx_clk,
    input  logic             rst,
    input  logic [DESER-1:0] word,
    input  logic             train_en,
    output logic             bitslip,
    output logic             lane_locked,
    output logic             lane_fail
`ifdef LVDS_ALIGN_SLIPCNT_EN
    ,
    output logic [7:0]       slip_cnt
`endif
);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int TW = $clog2(DESER + 1);
    localparam int XW = $clog2(MISS_MAX + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;

    state_t        state, state_n;
    logic [MW-1:0] match_cnt, match_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [TW-1:0] slip_tries, tries_n;
    logic [XW-1:0] miss_cnt, miss_n;
    logic          hit;

    assign hit         = (word == PATTERN);
    assign lane_locked = (state == LOCKED);
    assign lane_fail   = (state == FAIL);

    // State and counter registers; reset returns the lane to IDLE.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state      <= IDLE;
            match_cnt  <= '0;
            wait_cnt   <= '0;
            slip_tries <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_n;
            match_cnt  <= match_n;
            wait_cnt   <= wait_n;
            slip_tries <= tries_n;
            miss_cnt   <= miss_n;
        end
    end

    // Next-state, counter updates and the bitslip pulse.
    always_comb begin
        state_n = state;
        match_n = match_cnt;
        wait_n  = wait_cnt;
        tries_n = slip_tries;
        miss_n  = miss_cnt;
        bitslip = 1'b0;
        case (state)
            IDLE: if (train_en) state_n = CHECK;
            CHECK: begin
                if (!train_en) begin
                    state_n = IDLE;
                end else if (hit) begin
                    if (match_cnt == MW'(MATCH_CNT - 1)) begin
                        state_n = LOCKED;
                        match_n = '0;
                        miss_n  = '0;
                    end else begin
                        match_n = match_cnt + 1'b1;
                    end
                end else begin
                    match_n = '0;
                    state_n = (slip_tries == TW'(DESER)) ? FAIL : SLIP;
                end
            end
            SLIP: begin
                if (!train_en) begin
                    state_n = IDLE;
                end else begin
                    // A reset arriving in this cycle kills the pulse outright.
                    bitslip = !rst;
                    tries_n = slip_tries + 1'b1;
                    wait_n  = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!train_en)                          state_n = IDLE;
                else if (wait_cnt == WW'(SLIP_WAIT - 1)) state_n = CHECK;
                else                                    wait_n  = wait_cnt + 1'b1;
            end
            LOCKED: begin
                // With training off the link carries payload: hold lock blindly.
                if (train_en) begin
                    if (hit) begin
                        miss_n = '0;
                    end else if (miss_cnt == XW'(MISS_MAX - 1)) begin
                        state_n = CHECK;
                        match_n = '0;
                        tries_n = '0;
                        miss_n  = '0;
                    end else begin
                        miss_n = miss_cnt + 1'b1;
                    end
                end
            end
            FAIL: if (!train_en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Every route into IDLE starts the next attempt from clean counters.
        if (state_n == IDLE) begin
            match_n = '0;
            wait_n  = '0;
            tries_n = '0;
            miss_n  = '0;
        end
    end

`ifdef LVDS_ALIGN_SLIPCNT_EN
    // Saturating count of pulses issued since the lane last left IDLE.
    always_ff @(posedge rx_clk) begin
        if (rst)                                    slip_cnt <= '0;
        else if (state == IDLE && state_n == CHECK) slip_cnt <= '0;
        else if (bitslip && slip_cnt != 8'hFF)      slip_cnt <= slip_cnt + 8'd1;
    end
`endif
endmodule

module lvds_multi_align #(
    parameter int               LANES     = 2,
    parameter int               DESER     = 10,
    parameter logic [DESER-1:0] PATTERN   = 10'h3E0,
    parameter int               MATCH_CNT = 16,
    parameter int               SLIP_WAIT = 4,
    parameter int               MISS_MAX  = 4
) (
    input  logic                   rx_clk,
    input  logic                   rst,
    input  logic [LANES*DESER-1:0] rx_data,
    input  logic                   train_en,
    output logic [LANES-1:0]       bitslip,
    output logic [LANES-1:0]       lane_locked,
    output logic [LANES-1:0]       lane_fail,
    output logic                   all_locked
`ifdef LVDS_ALIGN_SLIPCNT_EN
    ,
    output logic [LANES*8-1:0]     slip_cnt
`endif
);
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lvds_align_lane #(
            .DESER(DESER), .PATTERN(PATTERN), .MATCH_CNT(MATCH_CNT),
            .SLIP_WAIT(SLIP_WAIT), .MISS_MAX(MISS_MAX)
        ) u_lane (
            .rx_clk     (rx_clk),
            .rst        (rst),
            .word       (rx_data[n*DESER +: DESER]),
            .train_en   (train_en),
            .bitslip    (bitslip[n]),
            .lane_locked(lane_locked[n]),
            .lane_fail  (lane_fail[n])
`ifdef LVDS_ALIGN_SLIPCNT_EN
            ,
            .slip_cnt   (slip_cnt[n*8 +: 8])
`endif
        );
    end

    // Link-level lock, registered one cycle behind the lane flags.
    always_ff @(posedge rx_clk) begin
        if (rst) all_locked <= 1'b0;
        else     all_locked <= &lane_locked;
    end
endmodule

// File: tb/tb_lvds_multi_align.sv
// Bench for lvds_multi_align: directed stimulus with a receiver model that
// rotates a lane's word by one bit per bitslip pulse. Expected output edges
// (channel, cycle, level) are queued by the stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_lvds_multi_align;
    localparam logic [9:0] PAT = 10'h3E0;

    logic        rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        train_en = 1'b0;
    logic [19:0] rx_data;
    logic [1:0]  bitslip, lane_locked, lane_fail;
    logic        all_locked;
`ifdef LVDS_ALIGN_SLIPCNT_EN
    logic [15:0] slip_cnt;
`endif

    lvds_multi_align dut (
        .rx_clk     (rx_clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .train_en   (train_en),
        .bitslip    (bitslip),
        .lane_locked(lane_locked),
        .lane_fail  (lane_fail),
        .all_locked (all_locked)
`ifdef LVDS_ALIGN_SLIPCNT_EN
        ,
        .slip_cnt   (slip_cnt)
`endif
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct packed { int cyc; logic val; } ev_t;
    ev_t expq [7][$];

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       mon_on = 1'b0;
    int         base [2] = '{0, 0};
    int         slips [2] = '{0, 0};
    logic [1:0] use_fix = 2'b00;
    logic [9:0] fixw [2] = '{10'h0, 10'h0};

    function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
        logic [9:0] r;
        int m;
        r = w;
        m = ((k % 10) + 10) % 10;
        for (int i = 0; i < m; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    function automatic string chname(input int i);
        case (i)
            0: return "bitslip0";
            1: return "bitslip1";
            2: return "locked0";
            3: return "locked1";
            4: return "fail0";
            5: return "fail1";
            default: return "all_locked";
        endcase
    endfunction

    // Receiver model: rotated training word, or a fixed/override word.
    always_comb begin
        rx_data = '0;
        for (int n = 0; n < 2; n++)
            rx_data[n*10 +: 10] = use_fix[n] ? fixw[n] : rotl(PAT, base[n] - slips[n]);
    end

    initial forever begin
        @(posedge rx_clk);
        cyc++;
    end

    // Receiver reacts to each sampled bitslip pulse.
    initial forever begin
        @(negedge rx_clk);
        for (int n = 0; n < 2; n++) if (bitslip[n] === 1'b1) slips[n]++;
    end

    // Monitor: every output edge must match the next queued expectation.
    initial begin
        logic [6:0] cur, prev;
        ev_t e;
        prev = 'x;
        forever begin
            @(negedge rx_clk);
            cur = {all_locked, lane_fail, lane_locked, bitslip};
            if (mon_on) begin
                for (int i = 0; i < 7; i++) begin
                    if (cur[i] !== prev[i]) begin
                        n_chk++;
                        if (expq[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL %s: unexpected edge to %b at cycle %0d", chname(i), cur[i], cyc);
                        end else begin
                            e = expq[i].pop_front();
                            if (e.cyc != cyc || e.val !== cur[i]) begin
                                n_fail++;
                                $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d",
                                         chname(i), cur[i], cyc, e.val, e.cyc);
                            end
                        end
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic expect_ev(input int ch, input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        expq[ch].push_back(e);
    endtask

    task automatic expect_pulse(input int ch, input int c);
        expect_ev(ch, c, 1'b1);
        expect_ev(ch, c + 1, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bitslip"}, 32'(bitslip), 32'h0);
        check({tag, "_locked"}, 32'(lane_locked), 32'h0);
        check({tag, "_fail"}, 32'(lane_fail), 32'h0);
        check({tag, "_all"}, 32'(all_locked), 32'h0);
    endtask

    // hi_mask: channels currently high, expected to fall on the reset edge.
    task automatic apply_reset(input logic [6:0] hi_mask);
        for (int i = 0; i < 7; i++) if (hi_mask[i]) expect_ev(i, cyc + 1, 1'b0);
        rst = 1'b1;
        train_en = 1'b0;
        use_fix = 2'b00;
        tick(2);
        check_reset_state("rst");
        rst = 1'b0;
    endtask

    task automatic start(output int t0);
        rst = 1'b0;
        train_en = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        int t0, t1, t3;
        tick(3);
        check_reset_state("por");
        mon_on = 1'b1;

        // Both lanes aligned: lock after 16 matches, no slips.
        start(t0);
        expect_ev(2, t0 + 17, 1'b1);
        expect_ev(3, t0 + 17, 1'b1);
        expect_ev(6, t0 + 18, 1'b1);
        tick(25);

        // Three misses then a hit: lock held.
        fixw[0] = 10'h000;
        use_fix[0] = 1'b1;
        tick(3);
        use_fix[0] = 1'b0;
        tick(5);

        // Four misses: lock drops, lane re-checks and relocks.
        use_fix[0] = 1'b1;
        t1 = cyc;
        expect_ev(2, t1 + 4, 1'b0);
        expect_ev(6, t1 + 5, 1'b0);
        expect_ev(2, t1 + 20, 1'b1);
        expect_ev(6, t1 + 21, 1'b1);
        tick(4);
        use_fix[0] = 1'b0;
        tick(25);

        // Payload mode: random data, lock held, no slips.
        train_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fixw[0] = 10'($urandom);
            fixw[1] = 10'($urandom);
            use_fix = 2'b11;
            tick(1);
        end
        use_fix = 2'b00;
        tick(2);
        check("payload_locked", 32'(lane_locked), 32'h3);
        train_en = 1'b1;
        tick(5);

        // Lane 1 rotated by 3: three pulses six cycles apart.
        apply_reset(7'b1001100);
        base[0] = slips[0];
        base[1] = slips[1] + 3;
        start(t0);
        expect_pulse(1, t0 + 2);
        expect_pulse(1, t0 + 8);
        expect_pulse(1, t0 + 14);
        expect_ev(2, t0 + 17, 1'b1);
        expect_ev(3, t0 + 35, 1'b1);
        expect_ev(6, t0 + 36, 1'b1);
        tick(45);
`ifdef LVDS_ALIGN_SLIPCNT_EN
        check("slip_cnt_lane0", 32'(slip_cnt[7:0]), 32'd0);
        check("slip_cnt_lane1", 32'(slip_cnt[15:8]), 32'd3);
`endif

        // Reset lands in the cycle a pulse is due: no pulse, then realign.
        apply_reset(7'b1001100);
        base[0] = slips[0];
        base[1] = slips[1] + 3;
        start(t0);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_reset_state("midrst");
        rst = 1'b0;
        t3 = cyc;
        expect_pulse(1, t3 + 2);
        expect_pulse(1, t3 + 8);
        expect_pulse(1, t3 + 14);
        expect_ev(2, t3 + 17, 1'b1);
        expect_ev(3, t3 + 35, 1'b1);
        expect_ev(6, t3 + 36, 1'b1);
        tick(45);

        // Lane 0 stuck at zero: ten pulses then FAIL; train_en low clears it.
        apply_reset(7'b1001100);
        base[1] = slips[1];
        fixw[0] = 10'h000;
        use_fix[0] = 1'b1;
        start(t0);
        for (int i = 0; i < 10; i++) expect_pulse(0, t0 + 2 + 6 * i);
        expect_ev(3, t0 + 17, 1'b1);
        expect_ev(4, t0 + 62, 1'b1);
        tick(70);
        train_en = 1'b0;
        expect_ev(4, cyc + 1, 1'b0);
        tick(5);
        check("fail_exit_locked1", 32'(lane_locked), 32'h2);

        // Every queued expectation must have been consumed.
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (expq[i].size() != 0) begin
                n_fail++;
                $display("FAIL %s: %0d expected edges never seen, first due at cycle %0d",
                         chname(i), expq[i].size(), expq[i][0].cyc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
